client_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares a single AXI-Stream NoC interface among NUM_CLIENTS client FIFOs. Each client presents a stream with valid/ready/last. The arbiter locks onto one client for a whole packet, from the first beat through the beat carrying tlast. It forwards beats through a one-entry output register and then rotates priority. It sits between the per-client stream buffers and the adder-side NoC interface.

---
 rtl/client_arbiter.sv | 145 ++++++++++++++
 tb/tb_client_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/client_arbiter.sv
// client_arbiter: packet-level round-robin arbiter feeding one AXI-Stream port through a one-beat output register.
// Optional per-client packet counters on pkt_count are enabled by defining CLIENT_ARB_STATS_EN.
`ifndef DATAW
`define DATAW 32
`endif
`ifndef AXIS_MAX_DATAW
`define AXIS_MAX_DATAW 64
`endif
`ifndef AXIS_DESTW
`define AXIS_DESTW 4
`endif
`ifndef AXIS_USERW
`define AXIS_USERW 8
`endif
`ifndef AXIS_IDW
`define AXIS_IDW 4
`endif
`ifndef AXIS_STRBW
`define AXIS_STRBW 8
`endif
`ifndef AXIS_KEEPW
`define AXIS_KEEPW 8
`endif

module client_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = `DATAW,
    parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]   req_tdata,
    input  logic [NUM_CLIENTS*`AXIS_DESTW-1:0]  req_tdest,
    input  logic [NUM_CLIENTS*`AXIS_USERW-1:0]  req_tuser,
    input  logic [NUM_CLIENTS-1:0]              req_tlast,
    input  logic [NUM_CLIENTS-1:0]              req_tvalid,
    output logic [NUM_CLIENTS-1:0]              req_tready,
    input  logic                                axis_tready,
    output logic                                axis_tvalid,
    output logic                                axis_tlast,
    output logic [`AXIS_MAX_DATAW-1:0]          axis_tdata,
    output logic [`AXIS_DESTW-1:0]              axis_tdest,
    output logic [`AXIS_USERW-1:0]              axis_tuser,
    output logic [`AXIS_IDW-1:0]                axis_tid,
    output logic [`AXIS_STRBW-1:0]              axis_tstrb,
    output logic [`AXIS_KEEPW-1:0]              axis_tkeep,
`ifdef CLIENT_ARB_STATS_EN
    output logic                                busy,
    output logic [NUM_CLIENTS*16-1:0]           pkt_count
`else
    output logic                                busy
`endif
);
    localparam int ODW   = `AXIS_MAX_DATAW;
    localparam int DESTW = `AXIS_DESTW;
    localparam int USERW = `AXIS_USERW;
    localparam int IDW   = `AXIS_IDW;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state, state_n;
    logic [IDX_W-1:0]       grant, grant_n, rr_ptr, rr_n, pick, tid_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   found, can_accept, xfer, pkt_done;
    int                     c;

    assign can_accept = ~axis_tvalid | axis_tready;
    assign busy       = state == LOCKED;
    assign xfer       = busy & req_tvalid[grant] & can_accept;
    assign pkt_done   = xfer & req_tlast[grant];
    // Backpressure reaches the granted client combinationally from axis_tready.
    assign req_tready = (busy & can_accept) ? NUM_CLIENTS'(1) << grant : '0;
    assign axis_tdata = ODW'(data_q);
    assign axis_tid   = IDW'(tid_q);
    assign axis_tstrb = '0;
    assign axis_tkeep = '0;

    // First requester at or after rr_ptr, searching modulo NUM_CLIENTS.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        c     = 0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            c = int'(rr_ptr) + k;
            c = (c >= NUM_CLIENTS) ? c - NUM_CLIENTS : c;
            if (!found && req_tvalid[c]) begin
                found = 1'b1;
                pick  = IDX_W'(c);
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        rr_n    = rr_ptr;
        if (state == IDLE && found) begin
            state_n = LOCKED;
            grant_n = pick;
        end else if (pkt_done) begin
            state_n = IDLE;
            rr_n    = (grant == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            axis_tvalid <= 1'b0;
            axis_tlast  <= 1'b0;
            data_q      <= '0;
            axis_tdest  <= '0;
            axis_tuser  <= '0;
            tid_q       <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            rr_ptr <= rr_n;
            if (xfer) begin
                axis_tvalid <= 1'b1;
                axis_tlast  <= req_tlast[grant];
                data_q      <= req_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                axis_tdest  <= req_tdest[int'(grant)*DESTW +: DESTW];
                axis_tuser  <= req_tuser[int'(grant)*USERW +: USERW];
                tid_q       <= grant;
            end else if (axis_tready) begin
                axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef CLIENT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!rst)
                pkt_count[i*16 +: 16] <= '0;
            else if (pkt_done && grant == IDX_W'(i))
                pkt_count[i*16 +: 16] <= pkt_count[i*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_client_arbiter.sv
// tb_client_arbiter: directed cycle-by-cycle checks of client_arbiter with a small per-client packet source model.
`ifndef DATAW
`define DATAW 32
`endif
`ifndef AXIS_MAX_DATAW
`define AXIS_MAX_DATAW 64
`endif
`ifndef AXIS_DESTW
`define AXIS_DESTW 4
`endif
`ifndef AXIS_USERW
`define AXIS_USERW 8
`endif
`ifndef AXIS_IDW
`define AXIS_IDW 4
`endif
`ifndef AXIS_STRBW
`define AXIS_STRBW 8
`endif
`ifndef AXIS_KEEPW
`define AXIS_KEEPW 8
`endif

module tb_client_arbiter;
    localparam int N     = 4;
    localparam int DW    = `DATAW;
    localparam int DESTW = `AXIS_DESTW;
    localparam int USERW = `AXIS_USERW;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic [N*DW-1:0]             req_tdata = '0;
    logic [N*DESTW-1:0]          req_tdest = '0;
    logic [N*USERW-1:0]          req_tuser = '0;
    logic [N-1:0]                req_tlast = '0;
    logic [N-1:0]                req_tvalid = '0;
    logic [N-1:0]                req_tready;
    logic                        axis_tready = 1'b1;
    logic                        axis_tvalid, axis_tlast, busy;
    logic [`AXIS_MAX_DATAW-1:0]  axis_tdata;
    logic [`AXIS_DESTW-1:0]      axis_tdest;
    logic [`AXIS_USERW-1:0]      axis_tuser;
    logic [`AXIS_IDW-1:0]        axis_tid;
    logic [`AXIS_STRBW-1:0]      axis_tstrb;
    logic [`AXIS_KEEPW-1:0]      axis_tkeep;
`ifdef CLIENT_ARB_STATS_EN
    logic [N*16-1:0]             pkt_count;
`endif

    always #5 clk = ~clk;

    client_arbiter #(.NUM_CLIENTS(N)) dut (
        .clk(clk), .rst(rst),
        .req_tdata(req_tdata), .req_tdest(req_tdest), .req_tuser(req_tuser),
        .req_tlast(req_tlast), .req_tvalid(req_tvalid), .req_tready(req_tready),
        .axis_tready(axis_tready), .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast),
        .axis_tdata(axis_tdata), .axis_tdest(axis_tdest), .axis_tuser(axis_tuser),
        .axis_tid(axis_tid), .axis_tstrb(axis_tstrb), .axis_tkeep(axis_tkeep),
`ifdef CLIENT_ARB_STATS_EN
        .busy(busy), .pkt_count(pkt_count)
`else
        .busy(busy)
`endif
    );

    int pass_cnt = 0, total = 0, fail_cnt = 0, cn = 0;
    string tname = "";
    int len [N];
    int idx [N];
    logic [DW-1:0] base [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Client sources: each presents beats base+0 .. base+len-1, tlast on the final one.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_tvalid[i]          = idx[i] < len[i];
            req_tdata[i*DW +: DW]  = base[i] + DW'(idx[i]);
            req_tlast[i]           = idx[i] == len[i] - 1;
        end
    endtask

    task automatic load(input int i, input int n, input logic [DW-1:0] b);
        len[i] = n; idx[i] = 0; base[i] = b;
    endtask

    task automatic step();
        logic [N-1:0] acc;
        #1;
        acc = req_tready & req_tvalid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) idx[i]++;
        drive();
    endtask

    task automatic begin_test(input string name);
        tname = name; cn = 0;
    endtask

    task automatic cyc(input logic b, input logic [N-1:0] r, input logic v,
                       input logic [DW-1:0] d, input logic l, input int id);
        #1;
        chk($sformatf("%s.c%0d.busy", tname, cn), busy, b);
        chk($sformatf("%s.c%0d.req_tready", tname, cn), req_tready, r);
        chk($sformatf("%s.c%0d.tvalid", tname, cn), axis_tvalid, v);
        if (v) begin
            chk($sformatf("%s.c%0d.tdata", tname, cn), axis_tdata, d);
            chk($sformatf("%s.c%0d.tlast", tname, cn), axis_tlast, l);
            chk($sformatf("%s.c%0d.tid", tname, cn), axis_tid, id);
            chk($sformatf("%s.c%0d.tdest", tname, cn), axis_tdest, id + 5);
            chk($sformatf("%s.c%0d.tuser", tname, cn), axis_tuser, id + 'h10);
        end
        cn++;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < N; i++) load(i, 0, '0);
        drive();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".tvalid"}, axis_tvalid, 0);
        chk({tag, ".tlast"}, axis_tlast, 0);
        chk({tag, ".tdata"}, axis_tdata, 0);
        chk({tag, ".tdest"}, axis_tdest, 0);
        chk({tag, ".tuser"}, axis_tuser, 0);
        chk({tag, ".tid"}, axis_tid, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".req_tready"}, req_tready, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_tdest[i*DESTW +: DESTW] = DESTW'(i + 5);
            req_tuser[i*USERW +: USERW] = USERW'(i + 'h10);
        end
        do_reset();
        #1;
        chk_zero("reset");
        chk("reset.tstrb", axis_tstrb, 0);
        chk("reset.tkeep", axis_tkeep, 0);

        begin_test("single");
        do_reset(); load(0, 3, 10); drive();
        cyc(0, 4'h0, 0, 0, 0, 0);
        cyc(1, 4'h1, 0, 0, 0, 0);
        cyc(1, 4'h1, 1, 10, 0, 0);
        cyc(1, 4'h1, 1, 11, 0, 0);
        cyc(0, 4'h0, 1, 12, 1, 0);
        cyc(0, 4'h0, 0, 0, 0, 0);

        begin_test("rr");
        do_reset(); load(0, 2, 'h20); load(1, 2, 'h30); load(2, 2, 'h40); drive();
        cyc(0, 4'h0, 0, 0, 0, 0);
        cyc(1, 4'h1, 0, 0, 0, 0);
        cyc(1, 4'h1, 1, 'h20, 0, 0);
        cyc(0, 4'h0, 1, 'h21, 1, 0);
        cyc(1, 4'h2, 0, 0, 0, 0);
        cyc(1, 4'h2, 1, 'h30, 0, 1);
        cyc(0, 4'h0, 1, 'h31, 1, 1);
        cyc(1, 4'h4, 0, 0, 0, 0);
        cyc(1, 4'h4, 1, 'h40, 0, 2);
        cyc(0, 4'h0, 1, 'h41, 1, 2);
        cyc(0, 4'h0, 0, 0, 0, 0);

        // rr_ptr is 3 here, so client 3 wins over client 0.
        begin_test("wrap");
        load(0, 1, 'h50); load(3, 1, 'h60); drive();
        cyc(0, 4'h0, 0, 0, 0, 0);
        cyc(1, 4'h8, 0, 0, 0, 0);
        cyc(0, 4'h0, 1, 'h60, 1, 3);
        cyc(1, 4'h1, 0, 0, 0, 0);
        cyc(0, 4'h0, 1, 'h50, 1, 0);
        cyc(0, 4'h0, 0, 0, 0, 0);

        // rr_ptr is 1 here, so client 2 wins over client 0.
        begin_test("rr1");
        load(0, 1, 'h70); load(2, 1, 'h80); drive();
        cyc(0, 4'h0, 0, 0, 0, 0);
        cyc(1, 4'h4, 0, 0, 0, 0);
        cyc(0, 4'h0, 1, 'h80, 1, 2);
        cyc(1, 4'h1, 0, 0, 0, 0);
        cyc(0, 4'h0, 1, 'h70, 1, 0);
        cyc(0, 4'h0, 0, 0, 0, 0);

        begin_test("bp");
        load(1, 6, 'hA0); drive();
        cyc(0, 4'h0, 0, 0, 0, 0);
        cyc(1, 4'h2, 0, 0, 0, 0);
        cyc(1, 4'h2, 1, 'hA0, 0, 1);
        axis_tready = 1'b0;
        repeat (5) cyc(1, 4'h0, 1, 'hA1, 0, 1);
        axis_tready = 1'b1;
        cyc(1, 4'h2, 1, 'hA1, 0, 1);
        cyc(1, 4'h2, 1, 'hA2, 0, 1);
        cyc(1, 4'h2, 1, 'hA3, 0, 1);
        cyc(1, 4'h2, 1, 'hA4, 0, 1);
        cyc(0, 4'h0, 1, 'hA5, 1, 1);
        cyc(0, 4'h0, 0, 0, 0, 0);

        begin_test("rstmid");
        load(3, 4, 'hC0); drive();
        cyc(0, 4'h0, 0, 0, 0, 0);
        cyc(1, 4'h8, 0, 0, 0, 0);
        cyc(1, 4'h8, 1, 'hC0, 0, 3);
        rst = 1'b0;
        cyc(1, 4'h8, 1, 'hC1, 0, 3);
        rst = 1'b1;
        len[3] = 0;
        drive();
        #1;
        chk_zero("rstmid.after");
        cyc(0, 4'h0, 0, 0, 0, 0);

        begin_test("post");
        load(1, 2, 'hE0); drive();
        cyc(0, 4'h0, 0, 0, 0, 0);
        cyc(1, 4'h2, 0, 0, 0, 0);
        cyc(1, 4'h2, 1, 'hE0, 0, 1);
        cyc(0, 4'h0, 1, 'hE1, 1, 1);
        cyc(0, 4'h0, 0, 0, 0, 0);

`ifdef CLIENT_ARB_STATS_EN
        do_reset();
        #1;
        chk("stats.reset", pkt_count, 0);
        load(0, 1, 'h1); load(2, 1, 'h2); drive();
        repeat (6) step();
        load(2, 1, 'h3); drive();
        repeat (6) step();
        load(2, 1, 'h4); drive();
        repeat (6) step();
        #1;
        chk("stats.count", pkt_count, 64'h0000_0003_0000_0001);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
